// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter in front of a shared 64-bit ALU: issue register S1 feeds the ALU, response register S2 returns tagged results.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins ties (no round-robin state).
module alu_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [OP_W-1:0]   s1_op;
  logic              s1_id;

  logic s2_free;
  logic s1_adv;
  logic can_accept;
  logic any_req;
  logic accept;
  logic winner;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  always_comb begin
    s2_free    = !rsp_valid || rsp_ready;
    s1_adv     = s1_valid && s2_free;
    can_accept = !s1_valid || s1_adv;
    any_req    = req0_valid || req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    winner     = !req0_valid;
`else
    // On a tie the port not granted last wins; otherwise the sole requester wins.
    if (req0_valid && req1_valid) winner = !last_grant;
    else                          winner = !req0_valid;
`endif
    accept     = any_req && can_accept;
    req0_ready = accept && !winner;
    req1_ready = accept && winner;
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_grant <= 1'b1;
    else if (accept) last_grant <= winner;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_id    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= winner ? req1_a  : req0_a;
      s1_b     <= winner ? req1_b  : req0_b;
      s1_op    <= winner ? req1_op : req0_op;
      s1_id    <= winner;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (s1_adv) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= s1_id;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // ALU operands track S1 even while it is stalled or empty.
  always_comb begin
    alu_a  = s1_a;
    alu_b  = s1_b;
    alu_op = s1_op;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed literal checks plus randomized traffic against an in-bench FIFO/latency model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_result;

  int compared = 0;
  int mismatched = 0;
  logic run = 1'b0;

  alu_arbiter #(.DATA_W(64), .OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {zero, result}; bne reports zero when operands differ.
  function automatic logic [64:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    logic [63:0] r;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0101: r = a - b;
      4'b1010: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      default: r = a ^ b;
    endcase
    return {(op == 4'b0101) ? (r != 64'd0) : (r == 64'd0), r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight ops form a FIFO of depth 2; each is presented no earlier than 2 cycles after accept.
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic        id;
    int          acc;
  } ent_t;

  ent_t q[$];
  logic lg = 1'b1;
  int   cyc = 0;

  function automatic logic m_rv();
    return (q.size() > 0) && (cyc >= q[0].acc + 2);
  endfunction

  function automatic logic m_cap();
    return (q.size() < 2) || rsp_ready;
  endfunction

  function automatic logic m_win();
    if (req0_valid && !req1_valid) return 1'b0;
    if (req1_valid && !req0_valid) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return (lg == 1'b1) ? 1'b0 : 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      lg  = 1'b1;
      cyc = 0;
    end else begin
      logic w, acc, rv;
      ent_t e;
      w   = m_win();
      acc = (req0_valid || req1_valid) && m_cap();
      rv  = m_rv();
      if (rv && rsp_ready) void'(q.pop_front());
      if (acc) begin
        e.a   = w ? req1_a  : req0_a;
        e.b   = w ? req1_b  : req0_b;
        e.op  = w ? req1_op : req0_op;
        e.id  = w;
        e.acc = cyc;
        q.push_back(e);
        lg = w;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && run) begin
      logic w, acc, rv;
      logic [64:0] zr;
      w   = m_win();
      acc = (req0_valid || req1_valid) && m_cap();
      rv  = m_rv();
      chk("m_req0_ready", req0_ready, acc && !w);
      chk("m_req1_ready", req1_ready, acc && w);
      chk("m_rsp_valid", rsp_valid, rv);
      if (rv) begin
        zr = alu_fn(q[0].a, q[0].b, q[0].op);
        chk("m_rsp_id", rsp_id, q[0].id);
        chk("m_rsp_result", rsp_result, zr[63:0]);
        chk("m_rsp_zero", rsp_zero, zr[64]);
      end
      if (q.size() == 2 || (q.size() == 1 && !rv)) begin
        chk("m_alu_a", alu_a, q[q.size()-1].a);
        chk("m_alu_b", alu_b, q[q.size()-1].b);
        chk("m_alu_op", alu_op, q[q.size()-1].op);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_rr_id(input int t);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return t[0];
`endif
  endfunction

  logic hs0, hs1;

  initial begin
    // Reset state
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run = 1'b1;
    step();

    // Single add 5+7
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'b0010;
    @(negedge clk); chk("add_ready", req0_ready, 1);
    step(); req0_valid = 0;
    step();
    @(negedge clk);
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_id", rsp_id, 0);
    chk("add_rsp_result", rsp_result, 12);
    chk("add_rsp_zero", rsp_zero, 0);
    step(); step();

    // beq then bne on port 1
    req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 4'b0110;
    @(negedge clk); chk("beq_ready", req1_ready, 1);
    step(); req1_op = 4'b0101;
    step(); req1_valid = 0;
    @(negedge clk);
    chk("beq_rsp_id", rsp_id, 1);
    chk("beq_rsp_result", rsp_result, 0);
    chk("beq_rsp_zero", rsp_zero, 1);
    step();
    @(negedge clk);
    chk("bne_rsp_id", rsp_id, 1);
    chk("bne_rsp_zero", rsp_zero, 0);
    step(); step();

    // Both ports continuously valid
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 4'b0010;
    req1_valid = 1; req1_a = 2; req1_b = 2; req1_op = 4'b0010;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t < 6) begin
        chk("tie_req0_ready", req0_ready, !exp_rr_id(t));
        chk("tie_req1_ready", req1_ready, exp_rr_id(t));
      end
      if (t >= 2) begin
        chk("tie_rsp_id", rsp_id, exp_rr_id(t - 2));
        chk("tie_rsp_result", rsp_result, exp_rr_id(t - 2) ? 64'd4 : 64'd2);
      end
      step();
      if (t == 5) begin req0_valid = 0; req1_valid = 0; end
    end
    step();

    // Backpressure: 3 stalled cycles while port 0 streams
    rsp_ready = 0; req0_valid = 1; req0_a = 1; req0_b = 0; req0_op = 4'b0010;
    @(negedge clk); chk("bp_ready_1", req0_ready, 1);
    step(); req0_a = 2;
    @(negedge clk); chk("bp_ready_2", req0_ready, 1);
    step(); req0_a = 3;
    @(negedge clk);
    chk("bp_ready_full", req0_ready, 0);
    chk("bp_hold_valid", rsp_valid, 1);
    chk("bp_hold_result", rsp_result, 1);
    step(); rsp_ready = 1;
    @(negedge clk);
    chk("bp_rsp_1", rsp_result, 1);
    chk("bp_ready_3", req0_ready, 1);
    step(); req0_valid = 0;
    @(negedge clk); chk("bp_rsp_2", rsp_result, 2);
    step();
    @(negedge clk); chk("bp_rsp_3", rsp_result, 3);
    step();
    @(negedge clk); chk("bp_drained", rsp_valid, 0);
    step();

    // Reset with S1 and S2 full
    rsp_ready = 0; req0_valid = 1; req0_a = 10; req0_b = 1; req0_op = 4'b0010;
    step(); req0_a = 20;
    step(); req0_valid = 0;
    @(negedge clk); chk("pre_rst_valid", rsp_valid, 1);
    #1 reset_n = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    step(); step();
    #2 reset_n = 1; rsp_ready = 1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); chk("post_rst_no_rsp", rsp_valid, 0);
    end
    step();
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_op = 4'b0010;
    req1_valid = 1; req1_a = 5; req1_b = 6; req1_op = 4'b0010;
    @(negedge clk);
    chk("post_rst_tie0", req0_ready, 1);
    chk("post_rst_tie1", req1_ready, 0);
    step(); req0_valid = 0;
    step(); req1_valid = 0;
    @(negedge clk);
    chk("post_rst_rsp_id", rsp_id, 0);
    chk("post_rst_rsp_result", rsp_result, 7);
    step();
    @(negedge clk);
    chk("post_rst_rsp_id2", rsp_id, 1);
    chk("post_rst_rsp_result2", rsp_result, 11);
    step();

    // Randomized traffic; requesters hold their offer until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      step();
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = {$urandom, $urandom};
        req0_b = ($urandom_range(0, 3) == 0) ? req0_a : {$urandom, $urandom};
        case ($urandom_range(0, 6))
          0: req0_op = 4'b0010; 1: req0_op = 4'b0110; 2: req0_op = 4'b0101; 3: req0_op = 4'b1010;
          4: req0_op = 4'b0000; 5: req0_op = 4'b0001; default: req0_op = 4'b1100;
        endcase
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = {$urandom, $urandom};
        req1_b = ($urandom_range(0, 3) == 0) ? req1_a : {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: req1_op = 4'b0110; 1: req1_op = 4'b0101; 2: req1_op = 4'b1010; default: req1_op = 4'b0010;
        endcase
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int t = 0; t < 5; t++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
